// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout, FSM states.
package icache_direct_pkg;

    localparam int NSETS  = 16;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int IIDX_W = $clog2(NSETS);
    localparam int ITAG_W = ADDR_W - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [WORD_W-1:0] data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake of the instruction cache.
interface icache_direct_if
    import icache_direct_pkg::*;
    ();

    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    // The cache itself answers fetches and issues memory reads.
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_direct_array.sv
// Frame storage: valid bits cleared by reset, tag/data left uninitialised.
module icache_direct_array
    import icache_direct_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IIDX_W-1:0] i_ridx,
    output icache_frame_t     o_rframe,
    input  logic              i_wen,
    input  logic [IIDX_W-1:0] i_widx,
    input  logic [ITAG_W-1:0] i_wtag,
    input  logic [WORD_W-1:0] i_wdata
);

    logic [NSETS-1:0]  r_valid;
    logic [ITAG_W-1:0] r_tag  [NSETS];
    logic [WORD_W-1:0] r_data [NSETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (i_wen) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_wen) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rframe = '{valid: r_valid[i_ridx], tag: r_tag[i_ridx], data: r_data[i_ridx]};

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-word fill on a miss.
module icache_direct
    import icache_direct_pkg::*;
(
    input  logic           CLK,
    input  logic           nRST,
    icache_direct_if.slave cif
);

    icache_state_t     r_state;
    icachef_t          r_missaddr;
    logic              r_iREN;

    logic [ITAG_W-1:0] w_reqTag;
    logic [IIDX_W-1:0] w_reqIdx;
    logic [ADDR_W-1:0] w_wordAddr;
    icache_frame_t     w_frame;
    logic              w_hit;
    logic              w_fill;

    assign w_reqTag   = cif.imemaddr[ADDR_W-1:IIDX_W+2];
    assign w_reqIdx   = cif.imemaddr[IIDX_W+1:2];
    assign w_wordAddr = cif.imemaddr & ~ADDR_W'(3);

    assign w_hit  = (r_state == IDLE) & cif.imemREN & w_frame.valid & (w_frame.tag == w_reqTag);
    assign w_fill = (r_state == MISS) & ~cif.iwait;

    icache_direct_array u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .i_ridx   (w_reqIdx),
        .o_rframe (w_frame),
        .i_wen    (w_fill),
        .i_widx   (r_missaddr.idx),
        .i_wtag   (r_missaddr.tag),
        .i_wdata  (cif.iload)
    );

    // A miss always runs to completion; redirects and dropped requests are seen only back in IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_missaddr <= '0;
            r_iREN     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cif.imemREN && !w_hit) begin
                        r_missaddr <= icachef_t'(w_wordAddr);
                        r_iREN     <= 1'b1;
                        r_state    <= MISS;
                    end
                end
                MISS: begin
                    if (!cif.iwait) begin
                        r_iREN  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_iREN  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cif.ihit     = w_hit;
    assign cif.imemload = w_hit ? w_frame.data : '0;
    assign cif.iREN     = r_iREN;
    assign cif.iaddr    = r_iREN ? ADDR_W'(r_missaddr) : '0;

endmodule
